// File: rtl/noc_local_ni.sv
// rtl/noc_local_ni.sv - local NI: PE-to-router TX with credit flow control, router-to-PE RX FWFT FIFO
// TX packs {payload, dest_x, dest_y} into one flit; RX returns one credit per flit popped.
module noc_local_ni #(
  parameter logic [3:0] XCOORD   = 4'd0,
  parameter logic [3:0] YCOORD   = 4'd0,
  parameter int         CREDITS  = 4,
  parameter int         RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  input  logic [3:0]  tx_dest_x_i,
  input  logic [3:0]  tx_dest_y_i,
  input  logic [7:0]  tx_payload_i,
  output logic        tx_ready_o,
  output logic [15:0] net_data_o,
  output logic        net_enable_o,
  input  logic        net_credit_i,
  input  logic [15:0] net_data_i,
  input  logic        net_enable_i,
  output logic        net_credit_o,
  output logic [15:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_pop_i,
  output logic [1:0]  err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
  localparam logic [AW:0]   RX_FULL     = (AW + 1)'(RX_DEPTH);

  if (CREDITS < 1 || CREDITS > 15 || RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0
      || XCOORD > 4'hF || YCOORD > 4'hF) begin : g_bad_params
    $error("noc_local_ni: illegal CREDITS/RX_DEPTH");
  end

  logic [CW-1:0] credit_q, credit_d;
  logic [15:0]   net_data_q, net_data_d;
  logic          net_enable_q, net_enable_d;
  logic          net_credit_q, net_credit_d;
  logic [1:0]    err_q, err_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [15:0]   mem_q [RX_DEPTH];

  logic accept;
  logic pop_ok;
  logic push_ok;
  logic rx_full;

  assign tx_ready_o = !rst && (credit_q != '0);
  assign accept     = tx_valid_i && tx_ready_o;

  assign rx_full = (count_q == RX_FULL);
  assign pop_ok  = rx_pop_i && (count_q != '0);
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok = net_enable_i && (!rx_full || pop_ok);

  always_comb begin
    credit_d     = credit_q;
    err_d        = err_q;
    net_data_d   = net_data_q;
    net_enable_d = accept;
    net_credit_d = pop_ok;
    count_d      = count_q;
    rd_d         = rd_q;
    wr_d         = wr_q;

    if (accept) begin
      net_data_d = {tx_payload_i, tx_dest_x_i, tx_dest_y_i};
    end

    if (accept && !net_credit_i) begin
      credit_d = credit_q - CW'(1);
    end else if (!accept && net_credit_i) begin
      if (credit_q == CREDITS_MAX) begin
        err_d[0] = 1'b1;
      end else begin
        credit_d = credit_q + CW'(1);
      end
    end

    if (net_enable_i && !push_ok) begin
      err_d[1] = 1'b1;
    end

    if (push_ok) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q     <= CREDITS_MAX;
      net_data_q   <= '0;
      net_enable_q <= 1'b0;
      net_credit_q <= 1'b0;
      err_q        <= '0;
      count_q      <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
    end else begin
      credit_q     <= credit_d;
      net_data_q   <= net_data_d;
      net_enable_q <= net_enable_d;
      net_credit_q <= net_credit_d;
      err_q        <= err_d;
      count_q      <= count_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  // When full with a pop, wr_q equals rd_q: the head is read out this cycle before the slot is reused.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_q] <= net_data_i;
    end
  end

  assign net_data_o   = net_data_q;
  assign net_enable_o = net_enable_q;
  assign net_credit_o = net_credit_q;
  assign err_o        = err_q;
  assign rx_valid_o   = (count_q != '0);
  assign rx_data_o    = (count_q != '0) ? mem_q[rd_q] : 16'h0000;

endmodule

// File: tb/tb_noc_local_ni.sv
// tb/tb_noc_local_ni.sv - self-checking bench for noc_local_ni
// Directed scenarios followed by a randomized run against a queue-based reference model.
module tb_noc_local_ni;

  localparam int CREDITS  = 4;
  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid_i;
  logic [3:0]  tx_dest_x_i;
  logic [3:0]  tx_dest_y_i;
  logic [7:0]  tx_payload_i;
  logic        tx_ready_o;
  logic [15:0] net_data_o;
  logic        net_enable_o;
  logic        net_credit_i;
  logic [15:0] net_data_i;
  logic        net_enable_i;
  logic        net_credit_o;
  logic [15:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_pop_i;
  logic [1:0]  err_o;

  int total = 0;
  int bad   = 0;

  noc_local_ni #(
    .XCOORD(4'd1), .YCOORD(4'd2), .CREDITS(CREDITS), .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_dest_x_i(tx_dest_x_i), .tx_dest_y_i(tx_dest_y_i),
    .tx_payload_i(tx_payload_i), .tx_ready_o(tx_ready_o),
    .net_data_o(net_data_o), .net_enable_o(net_enable_o), .net_credit_i(net_credit_i),
    .net_data_i(net_data_i), .net_enable_i(net_enable_i), .net_credit_o(net_credit_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_pop_i(rx_pop_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_valid_i   = 1'b0;
    tx_dest_x_i  = 4'h0;
    tx_dest_y_i  = 4'h0;
    tx_payload_i = 8'h00;
    net_credit_i = 1'b0;
    net_data_i   = 16'h0000;
    net_enable_i = 1'b0;
    rx_pop_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b want=0", tx_ready_o); end
    total++; if (net_enable_o !== 1'b0) begin bad++; $display("FAIL reset_net_enable got=%b want=0", net_enable_o); end
    total++; if (net_data_o !== 16'h0) begin bad++; $display("FAIL reset_net_data got=%h want=0000", net_data_o); end
    total++; if (net_credit_o !== 1'b0) begin bad++; $display("FAIL reset_net_credit got=%b want=0", net_credit_o); end
    total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid_o); end
    total++; if (rx_data_o !== 16'h0) begin bad++; $display("FAIL reset_rx_data got=%h want=0000", rx_data_o); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", err_o); end
    rst = 1'b0;
    #1;
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", tx_ready_o); end
    tick();
    total++; if (net_enable_o !== 1'b0) begin bad++; $display("FAIL idle_net_enable got=%b want=0", net_enable_o); end
    total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL idle_rx_valid got=%b want=0", rx_valid_o); end
  endtask

  task automatic test_tx_single();
    do_reset();
    tx_valid_i = 1'b1; tx_dest_x_i = 4'd2; tx_dest_y_i = 4'd1; tx_payload_i = 8'hA5;
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", tx_ready_o); end
    tick();
    tx_valid_i = 1'b0;
    total++; if (net_enable_o !== 1'b1) begin bad++; $display("FAIL single_enable got=%b want=1", net_enable_o); end
    total++; if (net_data_o !== 16'hA521) begin bad++; $display("FAIL single_data got=%h want=a521", net_data_o); end
    tick();
    total++; if (net_enable_o !== 1'b0) begin bad++; $display("FAIL single_enable_drop got=%b want=0", net_enable_o); end
    total++; if (net_data_o !== 16'hA521) begin bad++; $display("FAIL single_data_hold got=%h want=a521", net_data_o); end
  endtask

  task automatic test_credit_exhaust();
    logic [15:0] flit [5];
    do_reset();
    for (int i = 0; i < 5; i++) flit[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      tx_valid_i = 1'b1;
      {tx_payload_i, tx_dest_x_i, tx_dest_y_i} = flit[i];
      total++; if (tx_ready_o !== (i < CREDITS)) begin bad++; $display("FAIL exhaust_ready[%0d] got=%b want=%b", i, tx_ready_o, i < CREDITS); end
      tick();
      total++; if (net_enable_o !== (i < CREDITS)) begin bad++; $display("FAIL exhaust_enable[%0d] got=%b want=%b", i, net_enable_o, i < CREDITS); end
      if (i < CREDITS) begin
        total++; if (net_data_o !== flit[i]) begin bad++; $display("FAIL exhaust_data[%0d] got=%h want=%h", i, net_data_o, flit[i]); end
      end
    end
    net_credit_i = 1'b1;
    tick();
    net_credit_i = 1'b0;
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL exhaust_ready_after_credit got=%b want=1", tx_ready_o); end
    tick();
    tx_valid_i = 1'b0;
    total++; if (net_enable_o !== 1'b1) begin bad++; $display("FAIL exhaust_fifth_enable got=%b want=1", net_enable_o); end
    total++; if (net_data_o !== flit[4]) begin bad++; $display("FAIL exhaust_fifth_data got=%h want=%h", net_data_o, flit[4]); end
    total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL exhaust_ready_empty_again got=%b want=0", tx_ready_o); end
  endtask

  task automatic test_credit_corner();
    do_reset();
    tx_valid_i = 1'b1; tx_payload_i = 8'h11; tx_dest_x_i = 4'h3; tx_dest_y_i = 4'h4;
    tick();
    tick();
    // two credits left: accept and credit together must leave it at two
    net_credit_i = 1'b1;
    tick();
    net_credit_i = 1'b0;
    tick();
    total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL corner_one_left_ready got=%b want=1", tx_ready_o); end
    tick();
    tx_valid_i = 1'b0;
    total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL corner_zero_ready got=%b want=0", tx_ready_o); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL corner_no_err got=%b want=00", err_o); end
    net_credit_i = 1'b1;
    for (int i = 0; i < CREDITS; i++) tick();
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL corner_full_no_err got=%b want=00", err_o); end
    tick();
    net_credit_i = 1'b0;
    total++; if (err_o !== 2'b01) begin bad++; $display("FAIL corner_overflow_err got=%b want=01", err_o); end
    tick();
    total++; if (err_o !== 2'b01) begin bad++; $display("FAIL corner_err_sticky got=%b want=01", err_o); end
  endtask

  task automatic test_rx_basic();
    do_reset();
    net_enable_i = 1'b1; net_data_i = 16'h1234;
    tick();
    net_data_i = 16'h5678;
    total++; if (rx_valid_o !== 1'b1) begin bad++; $display("FAIL rx_fwft_valid got=%b want=1", rx_valid_o); end
    total++; if (rx_data_o !== 16'h1234) begin bad++; $display("FAIL rx_fwft_data got=%h want=1234", rx_data_o); end
    tick();
    net_enable_i = 1'b0;
    rx_pop_i = 1'b1;
    total++; if (net_credit_o !== 1'b0) begin bad++; $display("FAIL rx_no_credit_yet got=%b want=0", net_credit_o); end
    tick();
    total++; if (rx_data_o !== 16'h5678) begin bad++; $display("FAIL rx_second got=%h want=5678", rx_data_o); end
    total++; if (net_credit_o !== 1'b1) begin bad++; $display("FAIL rx_credit1 got=%b want=1", net_credit_o); end
    tick();
    rx_pop_i = 1'b0;
    total++; if (net_credit_o !== 1'b1) begin bad++; $display("FAIL rx_credit2 got=%b want=1", net_credit_o); end
    total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL rx_empty got=%b want=0", rx_valid_o); end
    tick();
    total++; if (net_credit_o !== 1'b0) begin bad++; $display("FAIL rx_credit_end got=%b want=0", net_credit_o); end
  endtask

  task automatic test_rx_overflow();
    logic [15:0] d [5];
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 5; i++) d[i] = 16'($urandom);
      net_enable_i = 1'b1;
      for (int i = 0; i < RX_DEPTH; i++) begin
        net_data_i = d[i];
        tick();
      end
      net_data_i = d[4];
      rx_pop_i = (pass == 1);
      tick();
      net_enable_i = 1'b0;
      rx_pop_i = 1'b0;
      total++; if (err_o !== ((pass == 0) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL ovf_err[%0d] got=%b want=%b", pass, err_o, (pass == 0) ? 2'b10 : 2'b00); end
      rx_pop_i = 1'b1;
      for (int i = pass; i < RX_DEPTH + pass; i++) begin
        total++; if (rx_data_o !== d[i]) begin bad++; $display("FAIL ovf_drain[%0d][%0d] got=%h want=%h", pass, i, rx_data_o, d[i]); end
        tick();
      end
      rx_pop_i = 1'b0;
      total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty[%0d] got=%b want=0", pass, rx_valid_o); end
    end
  endtask

  task automatic test_random();
    logic [15:0] q [$];
    int          credits;
    logic [1:0]  exp_err;
    logic [15:0] exp_data;
    logic        exp_en;
    logic        exp_cr;
    logic        acc;
    logic        popok;
    do_reset();
    credits  = CREDITS;
    exp_err  = 2'b00;
    exp_data = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      tx_valid_i   = ($urandom_range(0, 2) != 0);
      tx_dest_x_i  = 4'($urandom);
      tx_dest_y_i  = 4'($urandom);
      tx_payload_i = 8'($urandom);
      net_credit_i = (credits < CREDITS) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      net_enable_i = ($urandom_range(0, 1) == 1);
      net_data_i   = 16'($urandom);
      rx_pop_i     = ($urandom_range(0, 2) == 0);
      #1;
      total++; if (tx_ready_o !== (credits != 0)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, tx_ready_o, credits != 0); end
      total++; if (rx_valid_o !== (q.size() != 0)) begin bad++; $display("FAIL rnd_rx_valid c=%0d got=%b want=%b", c, rx_valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (rx_data_o !== q[0]) begin bad++; $display("FAIL rnd_rx_data c=%0d got=%h want=%h", c, rx_data_o, q[0]); end
      end
      acc   = tx_valid_i && (credits != 0);
      popok = rx_pop_i && (q.size() != 0);
      if (acc && !net_credit_i) credits--;
      else if (net_credit_i && !acc) begin
        if (credits == CREDITS) exp_err[0] = 1'b1;
        else credits++;
      end
      if (popok) void'(q.pop_front());
      if (net_enable_i) begin
        if (q.size() < RX_DEPTH) q.push_back(net_data_i);
        else exp_err[1] = 1'b1;
      end
      exp_en = acc;
      exp_cr = popok;
      if (acc) exp_data = {tx_payload_i, tx_dest_x_i, tx_dest_y_i};
      @(posedge clk);
      #1;
      total++; if (net_enable_o !== exp_en) begin bad++; $display("FAIL rnd_enable c=%0d got=%b want=%b", c, net_enable_o, exp_en); end
      total++; if (net_data_o !== exp_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, net_data_o, exp_data); end
      total++; if (net_credit_o !== exp_cr) begin bad++; $display("FAIL rnd_credit c=%0d got=%b want=%b", c, net_credit_o, exp_cr); end
      total++; if (err_o !== exp_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err_o, exp_err); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_tx_single();
    test_credit_exhaust();
    test_credit_corner();
    test_rx_basic();
    test_rx_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
